// File: rtl/add_pipe_n_bit_pkg.sv
// Shared mode encodings and mode-decode helpers for the pipelined add/subtract block.
package add_pipe_pkg;

    localparam logic [1:0] MODE_ADD_WRAP = 2'b00;
    localparam logic [1:0] MODE_SUB_WRAP = 2'b01;
    localparam logic [1:0] MODE_ADD_SAT  = 2'b10;
    localparam logic [1:0] MODE_SUB_SAT  = 2'b11;

    function automatic logic is_sub(input logic [1:0] mode);
        return mode[0];
    endfunction

    function automatic logic is_sat(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/add_pipe_n_bit_if.sv
// Operand/result handshake bundle between an upstream producer, the adder pipe and its consumer.
interface add_pipe_n_bit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/add_pipe_n_bit_seg.sv
// One carry-chain segment: SEG-bit ripple adder with carry in and carry out.
module add_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    // Segment sum with carry captured in the extra top bit
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    end

endmodule

// File: rtl/add_pipe_n_bit.sv
// WIDTH-bit add/subtract with the carry chain cut into STAGES registered segments,
// optional unsigned saturation and a single global advance enable for backpressure.
module add_pipe_n_bit
    import add_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    add_pipe_n_bit_if.slave   bus
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
        $error("add_pipe_n_bit: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             v_q      [STAGES];
    logic             v_d      [STAGES];
    logic [1:0]       mode_q   [STAGES];
    logic [1:0]       mode_d   [STAGES];
    logic             c_q      [STAGES];
    logic             c_d      [STAGES];
    logic [WIDTH-1:0] acc_q    [STAGES];
    logic [WIDTH-1:0] acc_d    [STAGES];
    logic [WIDTH-1:0] ra_q     [STAGES];
    logic [WIDTH-1:0] ra_d     [STAGES];
    logic [WIDTH-1:0] rb_q     [STAGES];
    logic [WIDTH-1:0] rb_d     [STAGES];

    logic             v_in_s   [STAGES];
    logic [1:0]       mode_in_s[STAGES];
    logic             c_in_s   [STAGES];
    logic [WIDTH-1:0] acc_in_s [STAGES];
    logic [WIDTH-1:0] ra_in_s  [STAGES];
    logic [WIDTH-1:0] rb_in_s  [STAGES];
    logic [WIDTH-1:0] acc_nx_s [STAGES];
    logic [SEG-1:0]   seg_sum_s[STAGES];
    logic             seg_co_s [STAGES];

    logic             adv_s;
    logic             cout_raw_s;
    logic [WIDTH-1:0] sat_sum_s;

    assign adv_s         = ~v_q[LAST] | bus.out_ready;
    assign bus.in_ready  = adv_s;
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = acc_q[LAST];
    assign bus.cout      = c_q[LAST];

    // Stage inputs: stage 0 takes the bus (b inverted for subtract), later stages take the previous register
    always_comb begin
        v_in_s[0]    = bus.in_valid;
        mode_in_s[0] = bus.mode;
        ra_in_s[0]   = bus.a;
        rb_in_s[0]   = is_sub(bus.mode) ? ~bus.b : bus.b;
        c_in_s[0]    = is_sub(bus.mode);
        acc_in_s[0]  = {WIDTH{1'b0}};
        for (int s = 1; s < STAGES; s++) begin
            v_in_s[s]    = v_q[s-1];
            mode_in_s[s] = mode_q[s-1];
            ra_in_s[s]   = ra_q[s-1];
            rb_in_s[s]   = rb_q[s-1];
            c_in_s[s]    = c_q[s-1];
            acc_in_s[s]  = acc_q[s-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_seg
        add_seg #(.SEG(SEG)) u_add_seg (
            .a   (ra_in_s[s][SEG-1:0]),
            .b   (rb_in_s[s][SEG-1:0]),
            .cin (c_in_s[s]),
            .sum (seg_sum_s[s]),
            .cout(seg_co_s[s])
        );
    end

    // Finished segments enter at the top and shift down, so after STAGES steps segment 0 sits at bit 0
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            acc_nx_s[s] = (acc_in_s[s] >> SEG) | (WIDTH'(seg_sum_s[s]) << (WIDTH - SEG));
        end
    end

    // Final-stage carry/borrow and saturation mux
    always_comb begin
        cout_raw_s = is_sub(mode_in_s[LAST]) ? ~seg_co_s[LAST] : seg_co_s[LAST];
        case (mode_in_s[LAST])
            MODE_ADD_WRAP, MODE_SUB_WRAP: sat_sum_s = acc_nx_s[LAST];
            MODE_ADD_SAT:  sat_sum_s = cout_raw_s ? {WIDTH{1'b1}} : acc_nx_s[LAST];
            MODE_SUB_SAT:  sat_sum_s = cout_raw_s ? {WIDTH{1'b0}} : acc_nx_s[LAST];
            default:       sat_sum_s = acc_nx_s[LAST];
        endcase
    end

    // Next state: every stage shifts together on adv, bubbles included, otherwise everything holds
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            v_d[s]    = v_q[s];
            mode_d[s] = mode_q[s];
            c_d[s]    = c_q[s];
            acc_d[s]  = acc_q[s];
            ra_d[s]   = ra_q[s];
            rb_d[s]   = rb_q[s];
        end
        if (adv_s) begin
            for (int s = 0; s < STAGES; s++) begin
                v_d[s]    = v_in_s[s];
                mode_d[s] = mode_in_s[s];
                c_d[s]    = seg_co_s[s];
                acc_d[s]  = acc_nx_s[s];
                ra_d[s]   = ra_in_s[s] >> SEG;
                rb_d[s]   = rb_in_s[s] >> SEG;
            end
            c_d[LAST]   = cout_raw_s;
            acc_d[LAST] = sat_sum_s;
        end else begin
            v_d[LAST] = v_q[LAST];
        end
    end

    // Stage registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s]    <= 1'b0;
                mode_q[s] <= 2'b00;
                c_q[s]    <= 1'b0;
                acc_q[s]  <= {WIDTH{1'b0}};
                ra_q[s]   <= {WIDTH{1'b0}};
                rb_q[s]   <= {WIDTH{1'b0}};
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s]    <= v_d[s];
                mode_q[s] <= mode_d[s];
                c_q[s]    <= c_d[s];
                acc_q[s]  <= acc_d[s];
                ra_q[s]   <= ra_d[s];
                rb_q[s]   <= rb_d[s];
            end
        end
    end

endmodule
